tdes_core_controller: RTL and testbench
=======================================

TDES_CORE_CONTROLLER -- requirements
Module: tdes_core_controller

Interface
REQ-001 SHALL have port HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-002 SHALL have port HRESET  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port enable  input  1  start request from the bus slave; sampled only in IDLE.
REQ-004 SHALL have port encryptionType  input  1  1 = encrypt (E-K1, D-K2, E-K3); 0 = decrypt (D-K3, E-K2, D-K1).
REQ-005 SHALL have port data  input  64  input block; bit 63 is DES bit 1.
REQ-006 SHALL have ports key1, key2, key3  input  64 each  DES keys, including parity bits.
REQ-007 SHALL have port outputEnable  output  1  result valid; level signal.
REQ-008 SHALL have port outputData  output  64  result block.
REQ-009 SHALL have port busy  output  1  high while a 48-round operation is in progress.
REQ-010 SHALL have port keyError  output  1  key parity failure flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-012 IDLE with enable=1 at edge N SHALL capture data, keys and encryptionType, load L/R from IP(data), clear pass and round counters, go to ROUND, and set busy=1 and outputEnable=0 at N.
REQ-013 ROUND SHALL perform exactly one Feistel round per cycle (E-expand, XOR subkey, S-boxes, P, XOR L): 16 rounds per pass, 3 passes, 48 cycles total.
REQ-014 At the end of passes 0 and 1, halves SHALL be swapped (L0'=R16, R0'=L16); inter-pass FP/IP are omitted because they cancel.
REQ-015 After round 15 of pass 2, outputData SHALL be set to FP(R16||L16), FSM SHALL go to DONE, and outputEnable=1 and busy=0 SHALL be set; this occurs at edge N+48.
REQ-016 DONE SHALL hold outputEnable=1 and outputData stable until the next accepted enable, then behave as IDLE.
REQ-017 enable SHALL be ignored while in ROUND, with no restart and no captured-value change; external changes to data or keys mid-operation SHALL have no effect.
REQ-018 The round counter SHALL wrap 15 to 0 and increment the pass counter; pass counter values of 3 or greater SHALL be unreachable.
REQ-019 Each pass SHALL load its key schedule from its pass key, using left shifts for an E pass and right shifts for a D pass.
REQ-020 The D-pass shift schedule SHALL be 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 With identical key1=key2=key3, the output SHALL equal single DES.

Reset
REQ-022 HRESET=0 at an edge SHALL force IDLE, counters 0, busy=0, outputEnable=0, outputData=0, keyError=0, and clear the captured registers to 0.
REQ-023 Reset mid-ROUND SHALL abandon the operation with no outputEnable pulse; the first enable after release SHALL start cleanly.

Configuration
REQ-024 Macro TDES_KEY_PARITY_CHECK_EN defined: at acceptance, each byte of key1..key3 SHALL be checked for odd parity.
REQ-025 With TDES_KEY_PARITY_CHECK_EN defined and any byte failing: FSM SHALL go directly to DONE at edge N+1 with outputData=0, outputEnable=1 and keyError=1; keyError SHALL clear on the next accepted enable.
REQ-026 Macro TDES_KEY_PARITY_CHECK_EN undefined: no check SHALL be made, parity bits SHALL be ignored, and keyError SHALL be tied to 0.

Structure
REQ-027 Package tdes_pkg SHALL hold the IP, FP, E, P, PC1, PC2 and S-box tables, the encrypt shift schedule, the state enum typedef, and constants ROUNDS_PER_PASS=16 and NUM_PASSES=3.
REQ-028 Sub-module des_key_schedule SHALL hold C/D registers, load PC1(key) on a load strobe, rotate per the direction input, and output the 48-bit PC2 subkey for the current round.

Verification
REQ-029 Encrypt, key1..3=133457799BBCDFF1, data=0123456789ABCDEF -> outputData=85E813540F0AB405 with outputEnable rising exactly 48 cycles after enable.
REQ-030 Decrypt, same keys, data=85E813540F0AB405 -> outputData=0123456789ABCDEF.
REQ-031 Random distinct keys: encrypt then decrypt the result -> original data returned; busy high for exactly 48 cycles each time.
REQ-032 enable pulsed again at round 20 with different data -> ignored; result matches the first request only.
REQ-033 HRESET=0 at round 30, then released -> outputs 0, no outputEnable; a new request gives the correct result.
REQ-034 With TDES_KEY_PARITY_CHECK_EN, key1=0000000000000000 -> keyError=1, outputData=0, outputEnable at N+1; without the macro -> a normal 48-cycle result and keyError=0.

Source files
------------

// File: rtl/tdes_pkg.sv
// Shared DES tables, permutation helpers and state/constant definitions for the TDES core.
package tdes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} tdes_state_e;

  localparam int ROUNDS_PER_PASS = 16;
  localparam int NUM_PASSES      = 3;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_PER_PASS - 1);
  localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);

  // Tables use the standard 1-based DES numbering, where bit 1 is the MSB.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Flattened S-boxes: index = {box, row, column}.
  localparam logic [3:0] SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // The decrypt schedule walks the encrypt schedule backwards: 0 first, then S[15], S[14], ...
  function automatic logic [1:0] dec_shift(input logic [3:0] round);
    return (round == 4'd0) ? 2'd0 : ENC_SHIFT[4'd0 - round];
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int s = 0; s < 8; s++) begin
      b = 6'(x >> (42 - 6 * s));
      y = {y[27:0], SBOX[{3'(s), b[5], b[0], b[4:1]}]};
    end
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    return p_perm(sbox_sub(e_expand(r) ^ k));
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^(8'(k >> (8 * b))));
    return ok;
  endfunction

endpackage

// File: rtl/des_key_schedule.sv
// DES key schedule: C/D registers loaded with PC1(key), rotated left (encrypt) or right (decrypt).
module des_key_schedule
  import tdes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic        decrypt,
  input  logic [3:0]  round,
  input  logic [63:0] key,
  output logic [47:0] subkey
);

  logic [27:0] c_q, d_q, c_rot, d_rot;
  logic [1:0]  amt;

  // The registers hold the pre-rotation value; this round's rotation is applied combinationally.
  always_comb begin
    amt   = decrypt ? dec_shift(round) : ENC_SHIFT[round];
    c_rot = c_q;
    d_rot = d_q;
    case ({decrypt, amt})
      3'b001: begin c_rot = {c_q[26:0], c_q[27]};    d_rot = {d_q[26:0], d_q[27]};    end
      3'b010: begin c_rot = {c_q[25:0], c_q[27:26]}; d_rot = {d_q[25:0], d_q[27:26]}; end
      3'b101: begin c_rot = {c_q[0], c_q[27:1]};     d_rot = {d_q[0], d_q[27:1]};     end
      3'b110: begin c_rot = {c_q[1:0], c_q[27:2]};   d_rot = {d_q[1:0], d_q[27:2]};   end
      default: ;
    endcase
    subkey = pc2({c_rot, d_rot});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= '0;
      d_q <= '0;
    end else if (load) begin
      {c_q, d_q} <= pc1(key);
    end else if (advance) begin
      c_q <= c_rot;
      d_q <= d_rot;
    end
  end

endmodule

// File: rtl/tdes_core_controller.sv
// Iterative Triple-DES (EDE) core: one Feistel round per HCLK, 48 rounds per block.
// Defining TDES_KEY_PARITY_CHECK_EN enables odd-parity checking of the keys at acceptance.
module tdes_core_controller
  import tdes_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        encryptionType,
  input  logic [63:0] data,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  output logic        outputEnable,
  output logic [63:0] outputData,
  output logic        busy,
  output logic        keyError
);

  tdes_state_e state, state_next;
  logic        accept, key_bad, last_round, final_round;
  logic        ks_load, pass_decrypt, enc_type_q;
  logic [3:0]  round_cnt;
  logic [1:0]  pass_cnt;
  logic [63:0] key1_q, key2_q, key3_q, ks_key;
  logic [31:0] l_q, r_q, new_r;
  logic [47:0] subkey;

`ifdef TDES_KEY_PARITY_CHECK_EN
  logic key_bad_q;

  always_ff @(posedge HCLK) begin
    if (!HRESET) key_bad_q <= 1'b0;
    else if (accept)
      key_bad_q <= !(key_parity_ok(key1) && key_parity_ok(key2) && key_parity_ok(key3));
  end

  assign key_bad  = key_bad_q;
  assign keyError = key_bad_q && (state == DONE);
`else
  assign key_bad  = 1'b0;
  assign keyError = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESET) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    busy         = (state == ROUND);
    outputEnable = (state == DONE);
    case (state)
      IDLE, DONE: if (enable) begin
        accept     = 1'b1;
        state_next = ROUND;
      end
      ROUND: if (key_bad || final_round) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // A pass is a decrypt pass when it is the middle pass of an encrypt, or an outer pass of a decrypt.
  always_comb begin
    last_round   = (round_cnt == LAST_ROUND);
    final_round  = last_round && (pass_cnt == LAST_PASS);
    pass_decrypt = enc_type_q ? (pass_cnt == 2'd1) : (pass_cnt != 2'd1);
    ks_load      = accept || ((state == ROUND) && last_round && !final_round);
    if (accept)                ks_key = encryptionType ? key1 : key3;
    else if (pass_cnt == 2'd0) ks_key = key2_q;
    else                       ks_key = enc_type_q ? key3_q : key1_q;
    new_r = l_q ^ feistel(r_q, subkey);
  end

  des_key_schedule u_key_schedule (
    .clk     (HCLK),
    .rst_n   (HRESET),
    .load    (ks_load),
    .advance (state == ROUND),
    .decrypt (pass_decrypt),
    .round   (round_cnt),
    .key     (ks_key),
    .subkey  (subkey)
  );

  // Between passes the halves are left swapped; the FP/IP pair that would sit there cancels out.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      l_q        <= '0;
      r_q        <= '0;
      round_cnt  <= '0;
      pass_cnt   <= '0;
      enc_type_q <= 1'b0;
      key1_q     <= '0;
      key2_q     <= '0;
      key3_q     <= '0;
      outputData <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip(data);
      round_cnt  <= '0;
      pass_cnt   <= '0;
      enc_type_q <= encryptionType;
      key1_q     <= key1;
      key2_q     <= key2;
      key3_q     <= key3;
    end else if (state == ROUND) begin
      if (key_bad) begin
        outputData <= '0;
      end else begin
        round_cnt <= round_cnt + 4'd1;
        if (final_round) begin
          pass_cnt   <= '0;
          outputData <= fp({new_r, r_q});
        end else if (last_round) begin
          pass_cnt <= pass_cnt + 2'd1;
          l_q      <= new_r;
        end else begin
          l_q <= r_q;
          r_q <= new_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdes_core_controller.sv
// Bench for tdes_core_controller: known answers, round trips, ignored enable, mid-run reset
// and the key-parity path (expectations follow TDES_KEY_PARITY_CHECK_EN).
module tb_tdes_core_controller;

  typedef struct {
    string       name;
    logic [63:0] exp_data;
    logic        check_data;
    logic        exp_key_error;
    int          exp_latency;
  } sb_entry_t;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  localparam logic        KAT_ENC  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [63:0] KAT_KEY  [4] = '{KEY_A, KEY_A, KEY_B, KEY_B};
  localparam logic [63:0] KAT_IN   [4] = '{PT_A, CT_A, 64'h8787878787878787, 64'h0};
  localparam logic [63:0] KAT_OUT  [4] = '{CT_A, PT_A, 64'h0, 64'h8787878787878787};

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        enable = 1'b0;
  logic        encryptionType = 1'b0;
  logic [63:0] data = '0, key1 = '0, key2 = '0, key3 = '0;
  logic        outputEnable, busy, keyError;
  logic [63:0] outputData;

  sb_entry_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  tdes_core_controller dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .enable         (enable),
    .encryptionType (encryptionType),
    .data           (data),
    .key1           (key1),
    .key2           (key2),
    .key3           (key3),
    .outputEnable   (outputEnable),
    .outputData     (outputData),
    .busy           (busy),
    .keyError       (keyError)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [63:0] rand_key();
    logic [63:0] k;
    logic [7:0]  by;
    k = '0;
    for (int b = 0; b < 8; b++) begin
      by    = 8'($urandom);
      by[0] = ~^by[7:1];
      k     = {k[55:0], by};
    end
    return k;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge with the entry queued.
  task automatic start_op(input string name, input logic enc, input logic [63:0] d, k1, k2, k3,
                          input logic [63:0] exp, input logic chk, input logic kerr, input int lat);
    sb_entry_t e;
    e.name = name; e.exp_data = exp; e.check_data = chk;
    e.exp_key_error = kerr; e.exp_latency = lat;
    sb_q.push_back(e);
    encryptionType = enc; data = d; key1 = k1; key2 = k2; key3 = k3;
    enable = 1'b1;
    @(posedge HCLK); #1;
    enable = 1'b0;
  endtask

  // Waits (bounded) for outputEnable, counting cycles and busy samples since the accepting edge.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (outputEnable !== 1'b1 && lat < 200) begin
      @(posedge HCLK); #1;
      lat++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_vec++; if (outputEnable !== 1'b0) begin n_err++; $display("[TB] FAIL reset outputEnable: got %b want 0", outputEnable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    n_vec++; if (outputData !== 64'h0) begin n_err++; $display("[TB] FAIL reset outputData: got %h want 0", outputData); end
    n_vec++; if (keyError !== 1'b0) begin n_err++; $display("[TB] FAIL reset keyError: got %b want 0", keyError); end
    enable = 1'b1;
    @(posedge HCLK); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_enable busy: got %b want 0", busy); end
    enable = 1'b0;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_known_vectors();
    sb_entry_t e;
    int lat, bcyc;
    for (int i = 0; i < 4; i++) begin
      start_op($sformatf("kat%0d", i), KAT_ENC[i], KAT_IN[i], KAT_KEY[i], KAT_KEY[i], KAT_KEY[i],
               KAT_OUT[i], 1'b1, 1'b0, 48);
      wait_done(lat, bcyc);
      e = sb_q.pop_front();
      n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
      n_vec++; if (lat !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.exp_latency); end
      n_vec++; if (bcyc !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s busy cycles: got %0d want %0d", e.name, bcyc, e.exp_latency); end
      n_vec++; if (keyError !== e.exp_key_error) begin n_err++; $display("[TB] FAIL %s keyError: got %b want %b", e.name, keyError, e.exp_key_error); end
      repeat (3) @(posedge HCLK);
      #1;
      n_vec++; if (outputEnable !== 1'b1 || outputData !== e.exp_data) begin
        n_err++; $display("[TB] FAIL %s hold: got oe=%b data=%h want oe=1 data=%h", e.name, outputEnable, outputData, e.exp_data);
      end
    end
  endtask

  task automatic test_roundtrip();
    sb_entry_t e;
    logic [63:0] k1, k2, k3, pt, ct;
    int lat, bcyc;
    for (int t = 0; t < 3; t++) begin
      k1 = rand_key(); k2 = rand_key(); k3 = rand_key();
      pt = {$urandom, $urandom};
      ct = '0;
      for (int step = 0; step < 2; step++) begin
        if (step == 0) start_op("rt_enc", 1'b1, pt, k1, k2, k3, 64'h0, 1'b0, 1'b0, 48);
        else           start_op("rt_dec", 1'b0, ct, k1, k2, k3, pt, 1'b1, 1'b0, 48);
        wait_done(lat, bcyc);
        e = sb_q.pop_front();
        if (step == 0) begin
          ct = outputData;
          n_vec++; if (ct === pt) begin n_err++; $display("[TB] FAIL %s cipher: got %h, must differ from %h", e.name, ct, pt); end
        end
        if (e.check_data) begin
          n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
        end
        n_vec++; if (bcyc !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s busy cycles: got %0d want %0d", e.name, bcyc, e.exp_latency); end
        n_vec++; if (lat !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.exp_latency); end
      end
    end
  endtask

  task automatic test_enable_ignored();
    sb_entry_t e;
    int lat, bcyc, drops;
    start_op("ignore", 1'b1, PT_A, KEY_A, KEY_A, KEY_A, CT_A, 1'b1, 1'b0, 48);
    repeat (20) @(posedge HCLK);
    #1;
    data = ~PT_A; key1 = KEY_B; key2 = 64'h0; key3 = KEY_B; encryptionType = 1'b0;
    enable = 1'b1;
    @(posedge HCLK); #1;
    enable = 1'b0;
    wait_done(lat, bcyc);
    e = sb_q.pop_front();
    n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
    n_vec++; if (lat + 21 !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat + 21, e.exp_latency); end
    drops = 0;
    repeat (60) begin
      @(posedge HCLK); #1;
      if (outputEnable !== 1'b1) drops++;
    end
    n_vec++; if (drops !== 0) begin n_err++; $display("[TB] FAIL %s restart: outputEnable low for %0d cycles, want 0", e.name, drops); end
  endtask

  task automatic test_reset_mid();
    sb_entry_t e;
    int lat, bcyc, oe_seen;
    start_op("reset_mid", 1'b1, PT_A, KEY_A, KEY_A, KEY_A, CT_A, 1'b1, 1'b0, 48);
    repeat (29) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    e = sb_q.pop_front();
    n_vec++; if (outputData !== 64'h0) begin n_err++; $display("[TB] FAIL %s outputData: got %h want 0", e.name, outputData); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL %s busy: got %b want 0", e.name, busy); end
    oe_seen = 0;
    repeat (60) begin
      @(posedge HCLK); #1;
      if (outputEnable !== 1'b0) oe_seen++;
    end
    n_vec++; if (oe_seen !== 0) begin n_err++; $display("[TB] FAIL %s outputEnable: high %0d cycles, want 0", e.name, oe_seen); end
    start_op("after_reset", 1'b0, CT_A, KEY_A, KEY_A, KEY_A, PT_A, 1'b1, 1'b0, 48);
    wait_done(lat, bcyc);
    e = sb_q.pop_front();
    n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
    n_vec++; if (lat !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.exp_latency); end
  endtask

  task automatic test_key_parity();
    sb_entry_t e;
    int lat, bcyc;
`ifdef TDES_KEY_PARITY_CHECK_EN
    start_op("parity_err", 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 1);
`else
    start_op("parity_off", 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8CA64DE9C1B123A7, 1'b1, 1'b0, 48);
`endif
    wait_done(lat, bcyc);
    e = sb_q.pop_front();
    n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
    n_vec++; if (lat !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.exp_latency); end
    n_vec++; if (keyError !== e.exp_key_error) begin n_err++; $display("[TB] FAIL %s keyError: got %b want %b", e.name, keyError, e.exp_key_error); end
    n_vec++; if (bcyc !== e.exp_latency) begin n_err++; $display("[TB] FAIL %s busy cycles: got %0d want %0d", e.name, bcyc, e.exp_latency); end
    start_op("parity_clear", 1'b1, PT_A, KEY_A, KEY_A, KEY_A, CT_A, 1'b1, 1'b0, 48);
    n_vec++; if (keyError !== 1'b0) begin n_err++; $display("[TB] FAIL parity_clear keyError at accept: got %b want 0", keyError); end
    wait_done(lat, bcyc);
    e = sb_q.pop_front();
    n_vec++; if (outputData !== e.exp_data) begin n_err++; $display("[TB] FAIL %s data: got %h want %h", e.name, outputData, e.exp_data); end
    n_vec++; if (keyError !== e.exp_key_error) begin n_err++; $display("[TB] FAIL %s keyError: got %b want %b", e.name, keyError, e.exp_key_error); end
  endtask

  initial begin
    $display("[TB] starting tdes_core_controller bench");
    test_reset();
    test_known_vectors();
    test_roundtrip();
    test_enable_ignored();
    test_reset_mid();
    test_key_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
